// File: rtl/rr_serial_arbiter.sv
// Round-robin arbiter that hands one serial channel to NUM_REQ requesters.
// Each grant shifts a word out MSB-first, then waits for an ack or times out.
module rr_serial_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       a_out,
    output logic                       a_valid,
    input  logic                       b_in
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t              r_state, w_state_n;
    logic [IDX_W-1:0]    r_ptr, w_ptr_n;
    logic [IDX_W-1:0]    r_owner, w_owner_n;
    logic [IDX_W-1:0]    w_win;
    logic                w_any;
    logic [DATA_W-1:0]   w_word;
    logic [DATA_W-1:0]   r_shreg, w_shreg_n;
    logic [BIT_W-1:0]    r_bitcnt, w_bitcnt_n;
    logic [WAIT_W-1:0]   r_waitcnt, w_waitcnt_n;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_n;
    logic [NUM_REQ-1:0]  r_done, w_done_n;
    logic                r_err, w_err_n;
    logic                r_busy;
    logic                r_a_out, w_a_out_n;
    logic                r_a_valid, w_a_valid_n;

    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % $unsigned(NUM_REQ);
        return IDX_W'(s);
    endfunction

    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        for (int unsigned i = 0; i < $unsigned(NUM_REQ); i++) begin
            if (!w_any && req[f_wrap(r_ptr, i)]) begin
                w_any = 1'b1;
                w_win = f_wrap(r_ptr, i);
            end
        end
    end

    assign w_word = req_data[32'(w_win) * DATA_W +: DATA_W];

    // a_out is registered, so the MSB is emitted at grant and shreg keeps the remaining bits
    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_owner_n   = r_owner;
        w_shreg_n   = r_shreg;
        w_bitcnt_n  = r_bitcnt;
        w_waitcnt_n = r_waitcnt;
        w_gnt_n     = '0;
        w_done_n    = '0;
        w_err_n     = 1'b0;
        w_a_out_n   = 1'b0;
        w_a_valid_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_n      = SHIFT;
                    w_owner_n      = w_win;
                    w_gnt_n[w_win] = 1'b1;
                    w_a_out_n      = w_word[DATA_W-1];
                    w_a_valid_n    = 1'b1;
                    w_shreg_n      = w_word << 1;
                    w_bitcnt_n     = '0;
                end
            end
            SHIFT: begin
                if (r_bitcnt == BIT_W'(DATA_W - 1)) begin
                    w_state_n   = WAIT_ACK;
                    w_waitcnt_n = '0;
                end else begin
                    w_a_out_n   = r_shreg[DATA_W-1];
                    w_a_valid_n = 1'b1;
                    w_shreg_n   = r_shreg << 1;
                    w_bitcnt_n  = r_bitcnt + BIT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (b_in) begin
                    w_done_n[r_owner] = 1'b1;
                    w_ptr_n           = f_wrap(r_owner, 1);
                    w_state_n         = IDLE;
                end else if (r_waitcnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    w_err_n   = 1'b1;
                    w_ptr_n   = f_wrap(r_owner, 1);
                    w_state_n = IDLE;
                end else begin
                    w_waitcnt_n = r_waitcnt + WAIT_W'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_waitcnt <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_a_out   <= 1'b0;
            r_a_valid <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ptr     <= w_ptr_n;
            r_owner   <= w_owner_n;
            r_shreg   <= w_shreg_n;
            r_bitcnt  <= w_bitcnt_n;
            r_waitcnt <= w_waitcnt_n;
            r_gnt     <= w_gnt_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
            r_busy    <= (w_state_n != IDLE);
            r_a_out   <= w_a_out_n;
            r_a_valid <= w_a_valid_n;
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign a_out   = r_a_out;
    assign a_valid = r_a_valid;

endmodule

// File: tb/tb_rr_serial_arbiter.sv
// Scoreboard bench for rr_serial_arbiter: stimulus queues expected events,
// a negedge monitor pops and checks them (grant, bits, done/err and timing).
module tb_rr_serial_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    localparam int EV_GNT  = 0;
    localparam int EV_BIT  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic             b_in = 1'b0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic             err;
    logic [1:0]       owner;
    logic             busy;
    logic             a_out;
    logic             a_valid;

    typedef struct {
        int kind;
        int val;
        int dt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_g  = 0;

    rr_serial_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .owner    (owner),
        .busy     (busy),
        .a_out    (a_out),
        .a_valid  (a_valid),
        .b_in     (b_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int v, input int d);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.dt   = d;
        q.push_back(e);
    endtask

    task automatic mon_evt(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                case (kind)
                    EV_GNT: begin
                        chk("gnt_onehot", int'(gnt), 1 << e.val);
                        chk("owner", int'(owner), e.val);
                        last_g = cyc;
                    end
                    EV_BIT: begin
                        chk("a_out_bit", int'(a_out), e.val);
                        chk("bit_timing", cyc - last_g, e.dt);
                        chk("busy_shift", int'(busy), 1);
                    end
                    EV_DONE: begin
                        chk("done_onehot", int'(done), 1 << e.val);
                        chk("done_timing", cyc - last_g, e.dt);
                        chk("done_no_err", int'(err), 0);
                        chk("busy_done", int'(busy), 0);
                    end
                    default: begin
                        chk("err_timing", cyc - last_g, e.dt);
                        chk("err_no_done", int'(done), 0);
                    end
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (gnt != '0)  mon_evt(EV_GNT);
        if (a_valid)    mon_evt(EV_BIT);
        if (done != '0) mon_evt(EV_DONE);
        if (err)        mon_evt(EV_ERR);
        if (!a_valid)   chk("a_out_idle_zero", int'(a_out), 0);
    end

    task automatic wait_gnt(output int lat);
        lat = 0;
        while (gnt == '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (gnt == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_wait: got no grant, expected one within 40 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        q.delete();
    endtask

    // ack_k: WAIT_ACK edge (1-based) carrying b_in=1, 0 = never ack
    task automatic run_xfer(input int w, input logic [DW-1:0] word, input int ack_k,
                            input logic shift_b, input logic [NR-1:0] drop_mask,
                            input int drop_d, output int lat);
        int n;
        push(EV_GNT, w, 0);
        for (int i = 0; i < DW; i++) push(EV_BIT, int'(word[DW-1-i]), i);
        if (ack_k != 0) push(EV_DONE, w, DW + ack_k);
        else            push(EV_ERR, 0, DW + TO);
        wait_gnt(lat);
        n = (ack_k != 0) ? DW + ack_k : DW + TO;
        for (int d = 0; d < n; d++) begin
            if (d == drop_d) req = req & ~drop_mask;
            b_in = (d < DW) ? shift_b : (ack_k != 0 && d == DW - 1 + ack_k);
            @(negedge clk);
        end
        b_in = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},     int'(gnt), 0);
        chk({tag, "_done"},    int'(done), 0);
        chk({tag, "_err"},     int'(err), 0);
        chk({tag, "_busy"},    int'(busy), 0);
        chk({tag, "_a_out"},   int'(a_out), 0);
        chk({tag, "_a_valid"}, int'(a_valid), 0);
        chk({tag, "_owner"},   int'(owner), 0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        b_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [DW-1:0] w5;

        do_reset();

        // single word, ack on 2nd WAIT_ACK edge
        req_data[1*DW +: DW] = 8'hA5;
        req = 4'b0010;
        run_xfer(1, 8'hA5, 2, 1'b0, 4'b0010, 0, lat);
        chk("t1_gnt_latency", lat, 1);
        drain();

        // round-robin with all requesting
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_xfer(k % NR, req_data[(k % NR)*DW +: DW], 1, 1'b0,
                     (k == 4) ? 4'b1111 : 4'b0000, 0, lat);
            chk("t2_gnt_gap", lat, 1);
        end
        drain();

        // timeout on requester 2, next search starts at 3
        req_data[2*DW +: DW] = 8'h5A;
        req = 4'b0100;
        run_xfer(2, 8'h5A, 0, 1'b0, 4'b0100, 0, lat);
        drain();
        req = 4'b1011;
        run_xfer(3, req_data[3*DW +: DW], 1, 1'b0, 4'b1011, 0, lat);
        drain();

        // ack during SHIFT is ignored; ack on the last allowed edge wins
        req = 4'b0010;
        run_xfer(1, req_data[1*DW +: DW], 0, 1'b1, 4'b0010, 0, lat);
        drain();
        req = 4'b0100;
        run_xfer(2, req_data[2*DW +: DW], TO, 1'b0, 4'b0100, 0, lat);
        drain();

        // reset in the middle of SHIFT
        w5 = 8'h3C;
        req_data[3*DW +: DW] = w5;
        req = 4'b1000;
        push(EV_GNT, 3, 0);
        for (int i = 0; i < 4; i++) push(EV_BIT, int'(w5[DW-1-i]), i);
        wait_gnt(lat);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t5_after_rst");
        chk("t5_queue_consumed", q.size(), 0);
        rst = 1'b0;
        req = 4'b1001;
        run_xfer(0, req_data[0*DW +: DW], 1, 1'b0, 4'b0001, 0, lat);
        chk("t5_gnt0_latency", lat, 1);
        run_xfer(3, w5, 1, 1'b0, 4'b1000, 0, lat);
        drain();

        // req dropped during SHIFT
        req_data[1*DW +: DW] = 8'hC3;
        req = 4'b0010;
        run_xfer(1, 8'hC3, 1, 1'b0, 4'b0010, 3, lat);
        drain();

        repeat (5) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
